// File: rtl/renode_bus_responder_ram.sv
// Memory-mapped bus responder backed by a 64-bit-wide RAM.
// Serves one sized read/write at a time after a fixed response latency.
module renode_bus_responder_ram #(
  parameter int unsigned AddressWidth    = 32,
  parameter int unsigned BaseAddress     = 0,
  parameter int unsigned Depth           = 256,
  parameter int unsigned ResponseLatency = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AddressWidth-1:0] req_addr,
  input  logic [1:0]              req_size,
  input  logic [63:0]             req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [63:0]             rsp_rdata,
  output logic                    rsp_error
);

  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [63:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    write_q;
  logic [AddressWidth-1:0] addr_q;
  logic [1:0]              size_q;
  logic [63:0]             wdata_q;
  logic [63:0]             mem_q [Depth];

  logic                    capture;
  logic                    mem_we;
  logic [AddressWidth:0]   offset;
  logic [3:0]              nbytes;
  logic                    below, over, misal, acc_err;
  logic [IdxW-1:0]         word_idx;
  logic [2:0]              lane;
  logic [7:0]              size_be, byte_en;
  logic [63:0]             wdata_sh, rd_sh, rd_masked;

  function automatic logic [63:0] expand_be(input logic [7:0] be);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  // Decode of the captured request; only consumed in EXEC.
  assign offset   = {1'b0, addr_q} - (AddressWidth+1)'(BaseAddress);
  assign nbytes   = 4'd1 << size_q;
  assign below    = addr_q < AddressWidth'(BaseAddress);
  assign over     = ({1'b0, offset} + (AddressWidth+2)'(nbytes)) > (AddressWidth+2)'(Depth * 8);
  assign misal    = (addr_q[2:0] & (nbytes[2:0] - 3'd1)) != 3'd0;
  assign acc_err  = below | over | misal;
  assign word_idx = offset[IdxW+2:3];
  assign lane     = offset[2:0];

  always_comb begin
    case (size_q)
      2'd0:    size_be = 8'h01;
      2'd1:    size_be = 8'h03;
      2'd2:    size_be = 8'h0F;
      default: size_be = 8'hFF;
    endcase
  end

  assign byte_en   = size_be << lane;
  assign wdata_sh  = wdata_q << {lane, 3'b000};
  assign rd_sh     = mem_q[word_idx] >> {lane, 3'b000};
  assign rd_masked = rd_sh & expand_be(size_be);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    capture = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (ResponseLatency > 0) begin
            state_d = WAIT;
            cnt_d   = 8'(ResponseLatency - 1);
          end else begin
            state_d = EXEC;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) state_d = EXEC;
        else               cnt_d   = cnt_q - 8'd1;
      end
      EXEC: begin
        err_d   = acc_err;
        rdata_d = (acc_err || write_q) ? 64'd0 : rd_masked;
        mem_we  = write_q & ~acc_err;
        state_d = RESP;
      end
      default: begin
        if (rsp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture; contents are don't-care until the next handshake.
  always_ff @(posedge clk) begin
    if (capture) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      size_q  <= req_size;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= 64'd0;
    end else if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

endmodule
